// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and defaults
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int WIDTH_DEF = 16;
endpackage

// File: rtl/serial_add_sub_full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic carry,
  output logic sum
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial add/sub, LSB first; status flags with SERIAL_ADD_SUB_FLAGS_EN
module serial_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ADD_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, rs_q, result_q, res_d;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, fa_sum, fa_carry, accept, last;
  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .c    (c_q),
    .carry(fa_carry),
    .sum  (fa_sum)
  );
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign accept    = in_valid && in_ready;
  assign last      = state_q == RUN && cnt_q == CW'(WIDTH - 1);
  assign res_d     = {fa_sum, rs_q[WIDTH-1:1]};
  assign result    = result_q;
  assign carry_out = cout_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // next state: accept -> serial run -> hold result until consumed
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = RUN;
    if (last) state_d = DONE;
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  // operand load, one bit per cycle through the adder cell, result capture on the last bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa_q     <= '0;
      sb_q     <= '0;
      rs_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      sa_q  <= a;
      sb_q  <= sub ? ~b : b;
      c_q   <= sub;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      sa_q  <= sa_q >> 1;
      sb_q  <= sb_q >> 1;
      rs_q  <= res_d;
      c_q   <= fa_carry;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        result_q <= res_d;
        cout_q   <= fa_carry;
      end
    end
`ifdef SERIAL_ADD_SUB_FLAGS_EN
  logic zero_q, neg_q, ovf_q;
  assign zero     = zero_q;
  assign neg      = neg_q;
  assign overflow = ovf_q;
  // flags: on the last bit c_q is the carry into the MSB, fa_carry the carry out of it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last) begin
      zero_q <= res_d == '0;
      neg_q  <= fa_sum;
      ovf_q  <= c_q ^ fa_carry;
    end
`endif
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized + directed check of serial_add_sub against an arithmetic model
module tb_serial_add_sub;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0, result;
  logic in_ready, out_valid, carry_out;
  int checks = 0, failures = 0;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
  logic zero, neg, overflow;
`endif
  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry_out(carry_out)
`ifdef SERIAL_ADD_SUB_FLAGS_EN
    ,
    .zero     (zero),
    .neg      (neg),
    .overflow (overflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_out(input logic [W-1:0] er, input logic ec, input logic eo);
    check("out_valid", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("result", result, er);
    check("carry_out", carry_out, ec);
`ifdef SERIAL_ADD_SUB_FLAGS_EN
    check("zero", zero, er == 0);
    check("neg", neg, er[W-1]);
    check("overflow", overflow, eo);
`else
    if (eo === 1'bx) check("overflow_model", eo, 0);
`endif
  endtask
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int hold);
    int n, xs, ys, sr;
    logic [W-1:0] er;
    logic ec, eo;
    xs = int'($signed(x));
    ys = int'($signed(y));
    sr = s ? xs - ys : xs + ys;
    er = s ? x - y : x + y;
    ec = s ? (x >= y) : ((int'(x) + int'(y)) > 65535);
    eo = (sr > 32767) || (sr < -32768);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = x; b = y; sub = s; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    check("in_ready_run", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, W);
    repeat (hold) begin
      check_out(er, ec, eo);
      @(negedge clk);
    end
    check_out(er, ec, eo);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    rst_n = 1;
    run_op(16'h0003, 16'h0004, 0, 0);
    run_op(16'hFFFF, 16'h0001, 0, 0);
    run_op(16'h0005, 16'h0007, 1, 0);
    run_op(16'h7FFF, 16'h0001, 0, 0);
    run_op(16'h8000, 16'h0001, 1, 0);
    run_op(16'h1111, 16'h2222, 0, 5);
    run_op(16'h4000, 16'h1000, 1, 0);
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (7) @(negedge clk);
    rst_n = 0;
    #1;
    check("midrun_in_ready", in_ready, 1);
    check("midrun_out_valid", out_valid, 0);
    check("midrun_result", result, 0);
    check("midrun_carry", carry_out, 0);
    repeat (20) @(negedge clk);
    check("midrun_no_pulse", out_valid, 0);
    rst_n = 1;
    run_op(16'h1234, 16'h1111, 0, 0);
    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial two's-complement adder/subtractor for the ALU datapath. It accepts two WIDTH-bit operands and an op select over a valid/ready handshake, then processes one bit per clock, LSB first, through a single full_adder cell and a carry flip-flop. It returns the result, carry-out and optional status flags over a second valid/ready handshake. It trades latency for area against the parallel ripple adder.

## Interface
- WIDTH, 16, operand/result width; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- carry_out  output  1  final carry. For subtract, 1 means no borrow.
- zero, neg, overflow  output  1 each  status flags (only with SERIAL_ADD_SUB_FLAGS_EN).

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: serial computation.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid&&in_ready. On that edge:
  - latch a into shift register sa.
  - latch b into sb, inverted when sub=1.
  - carry flop ← sub.
  - bit counter ← 0.
- RUN, each cycle:
  - full_adder inputs: a=sa[0], b=sb[0], c=carry flop.
  - sa and sb shift right.
  - result shift register shifts right with the sum inserted at the MSB.
  - carry flop ← full_adder carry.
  - counter increments.
- On the cycle with counter==WIDTH−1:
  - capture the carry into the MSB (the carry flop value) for overflow.
  - go to DONE.
- DONE→IDLE on out_ready. Until then, result and flags hold stable.
- Arithmetic is modulo 2^WIDTH. carry_out is the full_adder carry from bit WIDTH−1.
- in_ready is asserted only in IDLE. Inputs presented in RUN or DONE are ignored and must be held by the producer.
- result, carry_out and flags are registered and update only on the RUN→DONE transition.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - result=0, carry_out=0, zero=0, neg=0, overflow=0.
  - counter, shift registers and carry flop all 0.
- If the input is accepted at edge E0, bit i is registered at edge E(i+1). out_valid is high after edge E(WIDTH), giving a latency of WIDTH cycles.
- If out_ready is already high in DONE, the output handshake completes at E(WIDTH+1) and in_ready is high after it.
  - Minimum issue interval: WIDTH+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Reset asserted in any state, including mid-RUN: all state returns to reset values immediately. The operation in flight is discarded and no out_valid pulse is produced.
- Back-pressure: DONE is held indefinitely while out_ready=0.

## Configuration
- SERIAL_ADD_SUB_FLAGS_EN defined:
  - zero = (result==0).
  - neg = result[WIDTH−1].
  - overflow = carry-into-MSB XOR carry_out.
  - All three are registered alongside result.
- Undefined: zero, neg and overflow ports are absent, with no flag logic and no MSB-carry capture flop.

## Structure
- Shared package alu_pkg:
  - state enum typedef {IDLE, RUN, DONE}.
  - default WIDTH constant.
- One sub-module instance: the existing full_adder cell (ports a, b, c, carry, sum), used unmodified as the single serial bit slice.
- Counter width is $clog2(WIDTH).

## Test plan
All scenarios use WIDTH=16.
- 0x0003 + 0x0004, sub=0 → result 0x0007, carry_out 0, out_valid exactly 16 cycles after acceptance.
- 0xFFFF + 0x0001 → result 0x0000, carry_out 1, zero 1, overflow 0.
- 0x0005 − 0x0007 → result 0xFFFE, carry_out 0 (borrow), neg 1, overflow 0.
- 0x7FFF + 0x0001 → result 0x8000, overflow 1, neg 1. Also 0x8000 − 0x0001 → result 0x7FFF, overflow 1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid, result and flags stable and in_ready=0 throughout; handshake on the 6th cycle, then a new operand is accepted 1 cycle later.
- Reset mid-RUN: assert rst_n=0 at bit 7 of 0x1234+0x1111 → all outputs 0 and in_ready=1 immediately. After release, 0x1234+0x1111 → result 0x2345.
